// File: rtl/uart_key_tx_if.sv
// Key-byte write port of uart_key_tx: byte strobe from the keyboard decode path
// plus FIFO status returned to the producer.
interface uart_key_tx_if;
   logic [7:0] din;
   logic       din_valid;
   logic       fifo_full;
   logic       fifo_empty;
   logic       overflow;

   modport master (
      output din,
      output din_valid,
      input  fifo_full,
      input  fifo_empty,
      input  overflow
   );

   modport slave (
      input  din,
      input  din_valid,
      output fifo_full,
      output fifo_empty,
      output overflow
   );
endinterface

// File: rtl/uart_key_tx.sv
// Buffered UART transmitter: queues key bytes in a FIFO and sends them 8N1, LSB first.
// Define UART_TX_PARITY_EN to insert an even parity bit (8E1 frames).
module uart_key_tx #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   uart_key_tx_if.slave key,
   output logic         tx,
   output logic         busy
);
   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
   localparam int PTR_W        = $clog2(FIFO_DEPTH);
   localparam int CNT_W        = PTR_W + 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t            state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
   logic              parity_q, parity_d;
`endif

   logic [7:0]        mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;

   logic full, empty, push, pop, baud_end;

   // Fullness is judged on the registered count, so a write while full is dropped
   // even when the FSM pops in the same cycle.
   assign full     = (count_q == CNT_FULL);
   assign empty    = (count_q == '0);
   assign push     = key.din_valid & ~full;
   assign pop      = (state_q == IDLE) & ~empty;
   assign baud_end = (baud_q == BAUD_LAST);

   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      overflow_d = key.din_valid & full;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: the byte storage has no reset; pointers and count alone define valid entries.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= key.din;
   end

   always_comb begin
      // NOTE: every variable assigned here gets a default first, so no latch is inferred.
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      tx_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         IDLE: begin
            if (pop) begin
               shift_d  = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
               parity_d = ^mem_q[rd_ptr_q];
`endif
               baud_d   = '0;
               state_d  = START;
            end
         end
         START: begin
            tx_d = 1'b0;
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         DATA: begin
            tx_d = shift_q[0];
            if (baud_end) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            tx_d = parity_q;
            if (baud_end) begin
               baud_d  = '0;
               state_d = STOP;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
`endif
         STOP: begin
            tx_d = 1'b1;
            if (baud_end) begin
               baud_d  = '0;
               state_d = IDLE;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q   <= 1'b0;
`endif
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
         parity_q   <= parity_d;
`endif
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   assign tx             = tx_q;
   assign busy           = (state_q != IDLE);
   assign key.fifo_full  = full;
   assign key.fifo_empty = empty;
   assign key.overflow   = overflow_q;
endmodule
